// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester identifiers and the address/data width.
package cpu_pkg;

    localparam int ADDR_W = 16;

    // Requester identifiers, also the encoding of the round-robin pointer.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the shared memory port.
//   req/we/addr/wdata 0,1 : requester side (fetch = 0, data = 1)
//   gnt/ack 0,1, rdata    : per-requester grant, completion pulse, read data
//   busy                  : arbiter is not idle
//   memAddr/memRe/memWe/memWData/busD : the single memory port
// Handshake: a requester raises req with addr/we/wdata stable and keeps
// req high until its ack; ack is a single-cycle pulse, rdata is valid
// while ack is high. After ack the requester drops req or presents a new
// request; req seen during the ack cycle is ignored.
interface mem_port_arbiter_if;
    import cpu_pkg::*;

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [ADDR_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] memAddr;
    logic              memRe;
    logic              memWe;
    logic [ADDR_W-1:0] memWData;
    logic [ADDR_W-1:0] busD;

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, busD,
        output gnt0, gnt1, ack0, ack1, rdata, busy,
               memAddr, memRe, memWe, memWData
    );

    // Requester/memory side.
    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, busD,
        input  gnt0, gnt1, ack0, ack1, rdata, busy,
               memAddr, memRe, memWe, memWData
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req0, req1 : pending requests
//   last       : requester served most recently
//   valid      : at least one request pending
//   winner     : requester to serve (REQ_FETCH / REQ_DATA)
module rr_pick2
    import cpu_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = REQ_FETCH;
        if (req0 && req1) begin
            // On a tie the requester that was not served last goes next.
            winner = ~last;
        end else if (req1) begin
            winner = REQ_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (0) and
// data access (1). Each access runs IDLE -> ACCESS -> DONE; ACCESS lasts
// WAIT_CYCLES+1 cycles, DONE carries the one-cycle ack.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : requester handshakes and memory port (slave modport)
//   state_dbg : current FSM state
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int   WAIT_CYCLES = 0,
    parameter logic LAST_INIT   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus,
    output state_t                 state_dbg
);

    state_t            state_q, state_n;
    logic              last_q, last_n;
    logic [3:0]        wait_q, wait_n;
    logic              gnt0_q, gnt0_n, gnt1_q, gnt1_n;
    logic              ack0_q, ack0_n, ack1_q, ack1_n;
    logic              busy_q, busy_n;
    logic              re_q, re_n, we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n, wdata_q, wdata_n, rdata_q, rdata_n;

    logic pick_valid, pick_winner;

    rr_pick2 u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= LAST_INIT;
            wait_q  <= 4'd0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_n;
            last_q  <= last_n;
            wait_q  <= wait_n;
            gnt0_q  <= gnt0_n;
            gnt1_q  <= gnt1_n;
            ack0_q  <= ack0_n;
            ack1_q  <= ack1_n;
            busy_q  <= busy_n;
            re_q    <= re_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
        end
    end

    always_comb begin
        state_n = state_q;
        last_n  = last_q;
        wait_n  = wait_q;
        gnt0_n  = gnt0_q;
        gnt1_n  = gnt1_q;
        ack0_n  = ack0_q;
        ack1_n  = ack1_q;
        busy_n  = busy_q;
        re_n    = re_q;
        we_n    = we_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    addr_n  = pick_winner ? bus.addr1  : bus.addr0;
                    wdata_n = pick_winner ? bus.wdata1 : bus.wdata0;
                    we_n    = pick_winner ? bus.we1    : bus.we0;
                    re_n    = ~(pick_winner ? bus.we1  : bus.we0);
                    gnt0_n  = (pick_winner == REQ_FETCH);
                    gnt1_n  = (pick_winner == REQ_DATA);
                    busy_n  = 1'b1;
                    last_n  = pick_winner;
                    wait_n  = 4'(WAIT_CYCLES);
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_n = wait_q - 4'd1;
                end else begin
                    // Last access cycle: busD is sampled on this edge.
                    if (re_q) begin
                        rdata_n = bus.busD;
                    end
                    re_n    = 1'b0;
                    we_n    = 1'b0;
                    addr_n  = '0;
                    wdata_n = '0;
                    ack0_n  = gnt0_q;
                    ack1_n  = gnt1_q;
                    state_n = DONE;
                end
            end
            DONE: begin
                ack0_n  = 1'b0;
                ack1_n  = 1'b0;
                gnt0_n  = 1'b0;
                gnt1_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = busy_q;
    assign bus.rdata    = rdata_q;
    assign bus.memAddr  = addr_q;
    assign bus.memRe    = re_q;
    assign bus.memWe    = we_q;
    assign bus.memWData = wdata_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: one instance with WAIT_CYCLES=0 and one
// with WAIT_CYCLES=3; sel chooses which instance the stimulus drives and
// which instance's outputs the checks observe.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    logic        sel;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1, bus_d;

    mem_port_arbiter_if ifc0 ();
    mem_port_arbiter_if ifc3 ();
    state_t st0, st3;

    assign ifc0.req0 = req0 & ~sel;
    assign ifc0.req1 = req1 & ~sel;
    assign ifc3.req0 = req0 & sel;
    assign ifc3.req1 = req1 & sel;
    assign ifc0.we0 = we0;     assign ifc3.we0 = we0;
    assign ifc0.we1 = we1;     assign ifc3.we1 = we1;
    assign ifc0.addr0 = addr0; assign ifc3.addr0 = addr0;
    assign ifc0.addr1 = addr1; assign ifc3.addr1 = addr1;
    assign ifc0.wdata0 = wdata0; assign ifc3.wdata0 = wdata0;
    assign ifc0.wdata1 = wdata1; assign ifc3.wdata1 = wdata1;
    assign ifc0.busD = bus_d;  assign ifc3.busD = bus_d;

    mem_port_arbiter #(.WAIT_CYCLES(0), .LAST_INIT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(ifc0), .state_dbg(st0));
    mem_port_arbiter #(.WAIT_CYCLES(3), .LAST_INIT(1'b1)) dut3 (
        .clk(clk), .rst(rst), .bus(ifc3), .state_dbg(st3));

    // Outputs of the selected instance.
    logic        m_gnt0, m_gnt1, m_ack0, m_ack1, m_busy, m_re, m_we;
    logic [15:0] m_addr, m_wdata, m_rdata;
    state_t      m_state;
    assign m_gnt0  = sel ? ifc3.gnt0     : ifc0.gnt0;
    assign m_gnt1  = sel ? ifc3.gnt1     : ifc0.gnt1;
    assign m_ack0  = sel ? ifc3.ack0     : ifc0.ack0;
    assign m_ack1  = sel ? ifc3.ack1     : ifc0.ack1;
    assign m_busy  = sel ? ifc3.busy     : ifc0.busy;
    assign m_re    = sel ? ifc3.memRe    : ifc0.memRe;
    assign m_we    = sel ? ifc3.memWe    : ifc0.memWe;
    assign m_addr  = sel ? ifc3.memAddr  : ifc0.memAddr;
    assign m_wdata = sel ? ifc3.memWData : ifc0.memWData;
    assign m_rdata = sel ? ifc3.rdata    : ifc0.rdata;
    assign m_state = sel ? st3 : st0;

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    logic [16:0] exp_q[$];   // {requester, rdata}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected completion per ack of the selected instance
    // and checks grant/ack exclusion on both instances.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (m_ack0 || m_ack1) begin
                logic [16:0] e;
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'({m_ack1, m_ack0}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_port", 32'({m_ack1, m_ack0}), e[16] ? 32'd2 : 32'd1);
                    chk("rdata", 32'(m_rdata), 32'(e[15:0]));
                end
            end
            if (ifc0.gnt0 || ifc0.gnt1) chk("gnt_excl0", 32'(ifc0.gnt0 & ifc0.gnt1), 32'd0);
            if (ifc3.gnt0 || ifc3.gnt1) chk("gnt_excl3", 32'(ifc3.gnt0 & ifc3.gnt1), 32'd0);
            if (ifc0.ack0 || ifc0.ack1) chk("ack_excl0", 32'(ifc0.ack0 & ifc0.ack1), 32'd0);
            if (ifc3.ack0 || ifc3.ack1) chk("ack_excl3", 32'(ifc3.ack0 & ifc3.ack1), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 16'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 16'h0;
        bus_d = 16'hDEAD;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({m_gnt0, m_gnt1, m_ack0, m_ack1, m_busy, m_re, m_we}), 32'd0);
        chk({tag, "_addr"}, 32'(m_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(m_wdata), 32'd0);
        chk({tag, "_rdata"}, 32'(m_rdata), 32'd0);
        chk({tag, "_state"}, 32'(m_state), 32'(IDLE));
    endtask

    // One full transaction from a single requester; inputs are scrambled
    // during ACCESS and busD only carries bus_val in the last access cycle.
    task automatic run_txn(input logic port, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] bus_val,
                           input logic [15:0] exp_rd, input int wc);
        int  k = 0;
        int  bad = 0;
        bit  got = 0;
        exp_q.push_back({port, exp_rd});
        bus_d = 16'hDEAD;
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        @(posedge clk);
        while (!got && k <= wc + 4) begin
            @(negedge clk);
            if (m_ack0 || m_ack1) begin
                got = 1;
            end else begin
                if (m_re !== ~we || m_we !== we || m_addr !== addr || m_wdata !== wdata ||
                    (port ? m_gnt1 : m_gnt0) !== 1'b1 || m_busy !== 1'b1)
                    bad++;
                bus_d = (k == wc) ? bus_val : 16'hDEAD;
                addr0 = ~addr; addr1 = ~addr; wdata0 = ~wdata; wdata1 = ~wdata;
                we0 = ~we; we1 = ~we;
                k++;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_latency", 32'(k), 32'(wc + 1));
        chk("mem_phase_bad", 32'(bad), 32'd0);
        chk("mem_ctl_at_ack", 32'({m_re, m_we}), 32'd0);
        chk("mem_addr_at_ack", 32'(m_addr), 32'd0);
        chk("mem_wdata_at_ack", 32'(m_wdata), 32'd0);
        chk("gnt_at_ack", 32'(port ? m_gnt1 : m_gnt0), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("busy_after", 32'({m_busy, m_gnt0, m_gnt1, m_ack0, m_ack1}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit done;
        int base;
        sel = 1'b0;
        rst = 1'b1;
        idle_inputs();
        #12;
        sel = 1'b0; check_reset_outputs("reset0");
        sel = 1'b1; check_reset_outputs("reset3");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fetch read, no wait states.
        run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'hBEEF, 0);
        // Data write: rdata keeps the previous read value.
        run_txn(1'b1, 1'b1, 16'h2000, 16'h1234, 16'h5A5A, 16'hBEEF, 0);

        // Both requesters held: grants alternate 0,1,0,1.
        do_reset();
        exp_q.push_back({1'b0, 16'h5555});
        exp_q.push_back({1'b1, 16'h5555});
        exp_q.push_back({1'b0, 16'h5555});
        exp_q.push_back({1'b1, 16'h5555});
        base = ack_cnt;
        addr0 = 16'h0100; addr1 = 16'h0200; bus_d = 16'h5555;
        req0 = 1'b1; req1 = 1'b1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ack_cnt >= base + 4) done = 1;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_four_acks", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        chk("rr_idle", 32'({m_busy, m_gnt0, m_gnt1}), 32'd0);

        // Asynchronous reset in the middle of a WAIT_CYCLES=3 access.
        sel = 1'b1;
        do_reset();
        req0 = 1'b1; addr0 = 16'h0040; we0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_re", 32'(m_re), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Next fetch read is served normally, busD sampled on the last wait cycle.
        run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hCAFE, 16'hCAFE, 3);
        // WAIT_CYCLES=3 data write.
        run_txn(1'b1, 1'b1, 16'h0044, 16'hA5A5, 16'h1111, 16'hCAFE, 3);

        // Data request dropped during ACCESS still completes.
        exp_q.push_back({1'b1, 16'h7777});
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h3000; bus_d = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (m_ack1) done = 1;
        end
        chk("drop_ack1", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        chk("drop_idle", 32'({m_busy, m_gnt0, m_gnt1, m_ack0, m_ack1}), 32'd0);
        chk("drop_state", 32'(m_state), 32'(IDLE));

        repeat (2) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
